// File: rtl/matvec_row_engine.sv
// Row-serial matrix-vector engine: y = W*x, Q2.14, one row per result.
// Ports: clk/rst_n, start+vector_in, loader req/resp, result stream, busy/done.
module matvec_row_engine #(
  parameter int NUM_ROWS   = 64,
  parameter int NUM_COLS   = 64,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 14,
  parameter int BANDWIDTH  = 16,
  localparam int ADDR_WIDTH = $clog2(NUM_ROWS*NUM_COLS),
  localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NUM_COLS),
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [NUM_COLS*DATA_WIDTH-1:0]  vector_in,
  output logic                            matrix_enable,
  output logic [ADDR_WIDTH-1:0]           matrix_addr,
  input  logic [BANDWIDTH*DATA_WIDTH-1:0] matrix_data,
  input  logic                            matrix_ready,
  output logic [DATA_WIDTH-1:0]           result_out,
  output logic [ROW_W-1:0]                result_row,
  output logic                            result_valid,
  output logic                            busy,
  output logic                            done
);

  localparam int CHUNKS = NUM_COLS / BANDWIDTH;
  localparam int CHK_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int EXT    = ACC_WIDTH - 2*DATA_WIDTH;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] MAC  = 3'd3;
  localparam logic [2:0] EMIT = 3'd4;
  localparam logic [2:0] FIN  = 3'd5;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((2**(DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

  logic [2:0]                        state;
  logic [ROW_W-1:0]                  row;
  logic [CHK_W-1:0]                  chunk;
  logic signed [ACC_WIDTH-1:0]       acc;
  logic [BANDWIDTH*DATA_WIDTH-1:0]   chunk_reg;
  logic [NUM_COLS*DATA_WIDTH-1:0]    vec_reg;

  logic signed [ACC_WIDTH-1:0]       mac_sum;
  logic signed [2*DATA_WIDTH-1:0]    prod;
  logic signed [DATA_WIDTH-1:0]      w_k;
  logic signed [DATA_WIDTH-1:0]      x_k;
  logic signed [ACC_WIDTH-1:0]       shifted;
  logic [DATA_WIDTH-1:0]             sat_val;
  logic [31:0]                       addr_full;

  // BANDWIDTH parallel products against the current x slice
  always_comb begin
    mac_sum = acc;
    prod    = '0;
    w_k     = '0;
    x_k     = '0;
    for (int k = 0; k < BANDWIDTH; k++) begin
      w_k = chunk_reg[k*DATA_WIDTH +: DATA_WIDTH];
      x_k = vec_reg[(int'(chunk)*BANDWIDTH + k)*DATA_WIDTH +: DATA_WIDTH];
      prod = w_k * x_k;
      mac_sum = mac_sum + {{EXT{prod[2*DATA_WIDTH-1]}}, prod};
    end
  end

  // floor shift back to Q2.14, then clamp to the 16-bit range
  always_comb begin
    shifted = acc >>> FRAC_BITS;
    if (shifted > SAT_MAX)
      sat_val = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN)
      sat_val = SAT_MIN[DATA_WIDTH-1:0];
    else
      sat_val = shifted[DATA_WIDTH-1:0];
  end

  always_comb begin
    addr_full = 32'(int'(row)*NUM_COLS + int'(chunk)*BANDWIDTH);
    matrix_enable = (state == REQ);
    matrix_addr = matrix_enable ? addr_full[ADDR_WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row          <= '0;
      chunk        <= '0;
      acc          <= '0;
      chunk_reg    <= '0;
      vec_reg      <= '0;
      result_out   <= '0;
      result_row   <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          vec_reg <= vector_in;
          row     <= '0;
          chunk   <= '0;
          acc     <= '0;
          busy    <= 1'b1;
          state   <= REQ;
        end
        REQ: state <= WAIT;
        WAIT: if (matrix_ready) begin
          chunk_reg <= matrix_data;
          state     <= MAC;
        end
        MAC: begin
          acc <= mac_sum;
          if (chunk == CHK_W'(CHUNKS-1)) begin
            state <= EMIT;
          end else begin
            chunk <= chunk + 1'b1;
            state <= REQ;
          end
        end
        EMIT: begin
          result_out   <= sat_val;
          result_row   <= row;
          result_valid <= 1'b1;
          acc          <= '0;
          chunk        <= '0;
          if (row == ROW_W'(NUM_ROWS-1)) begin
            state <= FIN;
          end else begin
            row   <= row + 1'b1;
            state <= REQ;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_row_engine.sv
// Scoreboard bench for matvec_row_engine with a latency-17 loader model.
// Reference results come from plain integer dot products.
module tb_matvec_row_engine;

  localparam int NR = 4;
  localparam int NC = 32;
  localparam int DW = 16;
  localparam int FB = 14;
  localparam int BW = 16;
  localparam int L  = 17;
  localparam int AW = $clog2(NR*NC);

  logic clk;
  logic rst_n;
  logic start;
  logic [NC*DW-1:0] vector_in;
  logic matrix_enable;
  logic [AW-1:0] matrix_addr;
  logic [BW*DW-1:0] matrix_data;
  logic matrix_ready;
  logic [DW-1:0] result_out;
  logic [1:0] result_row;
  logic result_valid;
  logic busy;
  logic done;

  matvec_row_engine #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .DATA_WIDTH(DW),
    .FRAC_BITS(FB), .BANDWIDTH(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vector_in(vector_in),
    .matrix_enable(matrix_enable), .matrix_addr(matrix_addr),
    .matrix_data(matrix_data), .matrix_ready(matrix_ready),
    .result_out(result_out), .result_row(result_row),
    .result_valid(result_valid), .busy(busy), .done(done)
  );

  typedef struct {
    int row;
    int val;
  } exp_t;

  int tests = 0;
  int fails = 0;
  int w [NR*NC];
  int x [NC];
  exp_t sb [$];
  exp_t e;
  int addr_log [$];
  int en_cnt = 0;
  int valid_cnt = 0;
  bit hold_once = 0;
  bit spur_once = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference: exact dot product, floor shift, clamp
  task automatic model();
    for (int r = 0; r < NR; r++) begin
      longint s = 0;
      for (int c = 0; c < NC; c++)
        s += longint'(w[r*NC+c]) * longint'(x[c]);
      s = s >>> FB;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      sb.push_back('{r, int'(s)});
    end
  endtask

  // loader: latency L from enable to a one-cycle ready pulse
  initial begin
    int base;
    int extra;
    bit skip;
    skip = 0;
    matrix_ready = 0;
    matrix_data = '0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 0;
      if (matrix_enable) begin
        base = int'(matrix_addr);
        en_cnt++;
        addr_log.push_back(base);
        extra = hold_once ? 50 : 0;
        hold_once = 0;
        repeat (L-1+extra) begin
          @(negedge clk);
          matrix_data = {8{$urandom}};
        end
        matrix_ready = 1;
        for (int k = 0; k < BW; k++)
          matrix_data[k*DW +: DW] = DW'(w[base+k]);
        @(negedge clk);
        if (spur_once) begin
          spur_once = 0;
          matrix_data = {8{$urandom}};
          @(negedge clk);
          skip = 1;
        end
        matrix_ready = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (result_valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: row %0d value %0d",
                 result_row, $signed(result_out));
      end else begin
        e = sb.pop_front();
        chk("result_row", longint'(result_row), e.row);
        chk("result_out", $signed(result_out), e.val);
      end
    end
  end

  task automatic pack_x();
    for (int j = 0; j < NC; j++)
      vector_in[j*DW +: DW] = DW'(x[j]);
  endtask

  task automatic run(input bit inject_start);
    bit got;
    got = 0;
    pack_x();
    model();
    en_cnt = 0;
    valid_cnt = 0;
    addr_log.delete();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk("busy_after_start", busy, 1);
    for (int c = 0; c < 3000 && !got; c++) begin
      @(posedge clk); #1;
      if (c == 40 && inject_start) begin
        start = 1;
        vector_in = {16{$urandom}};
      end else begin
        start = 0;
      end
      if (done) got = 1;
    end
    start = 0;
    chk("done_seen", got, 1);
    chk("busy_at_done", busy, 0);
    chk("valid_count", valid_cnt, NR);
    chk("enable_count", en_cnt, NR*NC/BW);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  task automatic rand_fill(input int lo, input int hi);
    for (int i = 0; i < NR*NC; i++)
      w[i] = int'($urandom_range(hi-lo, 0)) + lo;
    for (int j = 0; j < NC; j++)
      x[j] = int'($urandom_range(hi-lo, 0)) + lo;
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_enable"}, matrix_enable, 0);
    chk({tag, "_addr"}, matrix_addr, 0);
    chk({tag, "_result_out"}, result_out, 0);
    chk({tag, "_result_row"}, result_row, 0);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    bit reached;
    rst_n = 0;
    start = 0;
    vector_in = '0;
    repeat (3) @(posedge clk);
    #1 zero_outputs("reset");
    rst_n = 1;

    // identity scaled to 1.0
    for (int i = 0; i < NR*NC; i++) w[i] = 0;
    for (int r = 0; r < NR; r++) w[r*NC+r] = 16384;
    for (int j = 0; j < NC; j++) x[j] = j*256;
    run(0);
    chk("addr_count", addr_log.size(), 8);
    for (int k = 0; k < 8; k++)
      chk("addr_seq", (addr_log.size() > k) ? addr_log[k] : -1, k*16);

    // both chunks summed, acc cleared per row
    for (int i = 0; i < NR*NC; i++) w[i] = 16384;
    for (int j = 0; j < NC; j++) x[j] = 512;
    run(0);

    // saturation both ways
    for (int i = 0; i < NR*NC; i++) w[i] = 32767;
    for (int j = 0; j < NC; j++) x[j] = 32767;
    run(0);
    for (int j = 0; j < NC; j++) x[j] = -32768;
    run(0);

    // long stall, spurious ready in MAC, start while busy
    rand_fill(-2048, 2047);
    hold_once = 1;
    spur_once = 1;
    run(1);

    // random operands
    rand_fill(-2048, 2047);
    run(0);
    rand_fill(-32768, 32767);
    run(0);

    // reset during row 2
    rand_fill(-4096, 4095);
    pack_x();
    model();
    en_cnt = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    reached = 0;
    for (int c = 0; c < 2000 && !reached; c++) begin
      @(posedge clk); #1;
      if (en_cnt >= 5) reached = 1;
    end
    chk("reach_row2", reached, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1 zero_outputs("midrun_reset");
    sb.delete();
    repeat (30) @(posedge clk);
    #1 rst_n = 1;
    run(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
